instr_fetch: RTL

- Program-counter and fetch-sequencing stage directly upstream of the instruction decoder.
- Holds the PC and the branch-target LUT, and drives the instruction-memory address each cycle.
- Consumes the decoder's PC_Jmp_Flag, PC_Beq_Flag, LUT_* controls and Ack (halt) to pick the next PC.
- Owns the Start/Done program handshake with the testbench/host.

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/instr_fetch_if.sv | 32 +++
 rtl/instr_fetch_branch_lut.sv | 34 +++
 rtl/instr_fetch.sv | 85 ++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: sizes, state
// encoding and the PC reset vector.
package instr_fetch_pkg;

    localparam int PC_W      = 10;
    localparam int LUT_AW    = 4;
    localparam int LUT_DEPTH = 1 << LUT_AW;

    localparam logic [PC_W-1:0] PC_RESET = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of decoder/host controls and fetch outputs. The fetch stage is the
// slave; the decoder/host side (or a testbench) is the master.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic              Start;
    logic [LUT_AW-1:0] Lut_Idx;
    logic [7:0]        Acc_In;
    logic              LUT_Write_En;
    logic              LUT_Load_Hi;
    logic              LUT_Read_En;
    logic              PC_Jmp_Flag;
    logic              PC_Beq_Flag;
    logic              Halt;
    logic [PC_W-1:0]   PC;
    logic              Fetch_En;
    logic              Running;
    logic              Done;

    modport master (
        output Start, Lut_Idx, Acc_In, LUT_Write_En, LUT_Load_Hi,
               LUT_Read_En, PC_Jmp_Flag, PC_Beq_Flag, Halt,
        input  PC, Fetch_En, Running, Done
    );

    modport slave (
        input  Start, Lut_Idx, Acc_In, LUT_Write_En, LUT_Load_Hi,
               LUT_Read_En, PC_Jmp_Flag, PC_Beq_Flag, Halt,
        output PC, Fetch_En, Running, Done
    );

endinterface

// File: rtl/instr_fetch_branch_lut.sv
// Branch-target register file: 16-bit entries written one byte at a time,
// read combinationally so a same-cycle write is not visible until next cycle.
module branch_lut
    import instr_fetch_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              we,
    input  logic              hi_sel,
    input  logic [LUT_AW-1:0] idx,
    input  logic [7:0]        wdata,
    output logic [15:0]       target
);

    logic [15:0] mem_q [LUT_DEPTH];

    // Byte-select write; the untouched byte of the entry keeps its value.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                mem_q[i] <= 16'h0000;
            end
        end else if (we) begin
            if (hi_sel) begin
                mem_q[idx][15:8] <= wdata;
            end else begin
                mem_q[idx][7:0] <= wdata;
            end
        end
    end

    assign target = mem_q[idx];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: program counter, IDLE/RUN/DONE sequencing and the
// Start/Done handshake. Branch targets come from the branch_lut instance.
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic          Clk,
    input  logic          Reset,
    instr_fetch_if.slave  bus
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     lut_target;
    logic            lut_we;
    logic            take_branch;
    logic [15-PC_W:0] unused_target_hi;

    // LUT writes only land while the program is running.
    assign lut_we = bus.LUT_Write_En && (state_q == RUN);

    branch_lut u_branch_lut (
        .Clk    (Clk),
        .Reset  (Reset),
        .we     (lut_we),
        .hi_sel (bus.LUT_Load_Hi),
        .idx    (bus.Lut_Idx),
        .wdata  (bus.Acc_In),
        .target (lut_target)
    );

    // Target bits above the program space are dropped.
    assign unused_target_hi = lut_target[15:PC_W];

    // A flag without LUT_Read_En is just a sequential step.
    assign take_branch = bus.LUT_Read_En && (bus.PC_Jmp_Flag || bus.PC_Beq_Flag);

    // State and PC registers; reset aborts any in-flight instruction.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= PC_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state/PC selection: Start beats Halt, Halt beats branch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.Start) begin
            state_d = RUN;
            pc_d    = PC_RESET;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RUN: begin
                    if (bus.Halt) begin
                        state_d = DONE;
                    end else if (take_branch) begin
                        pc_d = lut_target[PC_W-1:0];
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                    pc_d    = PC_RESET;
                end
            endcase
        end
    end

    assign bus.PC       = pc_q;
    assign bus.Running  = (state_q == RUN);
    assign bus.Fetch_En = (state_q == RUN);
    assign bus.Done     = (state_q == DONE);

endmodule
